// File: rtl/regfile_mp_pkg.sv
// Shared definitions for the multi-port register file: address-width helper,
// clear-sequencer state encoding and the hardwired-zero register index.
package regfile_pkg;

    // Address width for a register count; never below 1 so NREG=2 still works.
    function automatic int calc_aw(input int nreg);
        return (nreg <= 2) ? 1 : $clog2(nreg);
    endfunction

    typedef enum logic [0:0] {
        RF_IDLE  = 1'b0,
        RF_CLEAR = 1'b1
    } rf_state_e;

    // x0 is never stored and always reads as zero.
    localparam int RF_ZERO_ADDR = 0;

endpackage

// File: rtl/regfile_mp_if.sv
// Bus between decode/writeback and the register file. The master drives
// addresses, write data and clear requests; the slave (the register file)
// returns read data and the ready flag.
interface regfile_mp_if
    import regfile_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int NREG = 32,
    parameter int NRD  = 2,
    parameter int NWR  = 1
) ();
    localparam int AW = calc_aw(NREG);

    logic                 clr_req;
    logic                 ready;
    logic [NWR-1:0]       we;
    logic [NWR*AW-1:0]    waddr;
    logic [NWR*XLEN-1:0]  wdata;
    logic [NRD*AW-1:0]    raddr;
    logic [NRD*XLEN-1:0]  rdata;

    modport master (
        output clr_req, we, waddr, wdata, raddr,
        input  ready, rdata
    );

    modport slave (
        input  clr_req, we, waddr, wdata, raddr,
        output ready, rdata
    );
endinterface

// File: rtl/regfile_mp_clear_seq.sv
// Clear sequencer: after reset or a clear request it walks entries 1..NREG-1,
// one per cycle, issuing a zero write for each. ready is low while walking.
module regfile_clear_seq
    import regfile_pkg::*;
#(
    parameter  int NREG = 32,
    localparam int AW   = calc_aw(NREG)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clr_req,
    output logic          ready,
    output logic          clr_we,
    output logic [AW-1:0] clr_addr
);
    rf_state_e     state_q, state_d;
    logic [AW-1:0] ctr_q, ctr_d;

    // State and counter registers; reset always restarts the walk at entry 1.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= RF_CLEAR;
            ctr_q   <= AW'(1);
        end else begin
            state_q <= state_d;
            ctr_q   <= ctr_d;
        end
    end

    // Next-state: requests only start a clear from IDLE; the walk ends after entry NREG-1.
    always_comb begin
        state_d = state_q;
        ctr_d   = ctr_q;
        case (state_q)
            RF_IDLE: begin
                if (clr_req) begin
                    state_d = RF_CLEAR;
                    ctr_d   = AW'(1);
                end
            end
            RF_CLEAR: begin
                ctr_d = ctr_q + AW'(1);
                if (ctr_q == AW'(NREG - 1)) begin
                    state_d = RF_IDLE;
                end
            end
            default: begin
                state_d = RF_CLEAR;
                ctr_d   = AW'(1);
            end
        endcase
    end

    // Outputs decoded from the current state.
    always_comb begin
        ready    = (state_q == RF_IDLE);
        clr_we   = (state_q == RF_CLEAR);
        clr_addr = ctr_q;
    end
endmodule

// File: rtl/regfile_mp.sv
// Multi-port integer register file with x0 hardwired to zero, NWR write ports
// (highest index wins on address collisions), NRD combinational read ports and
// a built-in clear sequencer. Optional macro REGFILE_BYPASS_EN adds same-cycle
// write-to-read forwarding; without it readers see the old value until the edge.
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int NREG = 32,
    parameter int NRD  = 2,
    parameter int NWR  = 1
) (
    input logic         clk,
    input logic         reset,
    regfile_mp_if.slave bus
);
    localparam int AW = calc_aw(NREG);

    logic            ready;
    logic            clr_we;
    logic [AW-1:0]   clr_addr;

    logic [XLEN-1:0] mem_q [NREG];

    // Unpacked views of the packed write ports.
    logic            wen   [NWR];
    logic [AW-1:0]   wa    [NWR];
    logic [XLEN-1:0] wd    [NWR];

    regfile_clear_seq #(
        .NREG (NREG)
    ) u_clear_seq (
        .clk      (clk),
        .reset    (reset),
        .clr_req  (bus.clr_req),
        .ready    (ready),
        .clr_we   (clr_we),
        .clr_addr (clr_addr)
    );

    assign bus.ready = ready;

    genvar gi;
    generate
        for (gi = 0; gi < NWR; gi++) begin : g_wr
            assign wen[gi] = bus.we[gi];
            assign wa[gi]  = bus.waddr[gi*AW +: AW];
            assign wd[gi]  = bus.wdata[gi*XLEN +: XLEN];
        end
    endgenerate

    // Storage update: the sequencer owns the array while clearing; otherwise
    // ports are applied in ascending order so the highest port's write lands last.
    always_ff @(posedge clk) begin
        if (clr_we) begin
            mem_q[clr_addr] <= '0;
        end else if (ready) begin
            for (int p = 0; p < NWR; p++) begin
                if (wen[p] && (wa[p] != AW'(RF_ZERO_ADDR))) begin
                    mem_q[wa[p]] <= wd[p];
                end
            end
        end
    end

    generate
        for (gi = 0; gi < NRD; gi++) begin : g_rd
            logic [AW-1:0]   ra;
            logic [XLEN-1:0] rd;

            assign ra = bus.raddr[gi*AW +: AW];

            // Read mux: zero for x0 and during a clear, otherwise the stored
            // value (or the highest-port in-flight write when forwarding is built in).
            always_comb begin
                rd = '0;
                if (ready && (ra != AW'(RF_ZERO_ADDR))) begin
                    rd = mem_q[ra];
`ifdef REGFILE_BYPASS_EN
                    for (int p = 0; p < NWR; p++) begin
                        if (wen[p] && (wa[p] == ra)) begin
                            rd = wd[p];
                        end
                    end
`endif
                end
            end

            assign bus.rdata[gi*XLEN +: XLEN] = rd;
        end
    endgenerate
endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp with two write and two read ports.
// Inputs change on the falling edge; outputs are checked 1 time unit later
// or on a falling edge, well away from the rising edge.
module tb_regfile_mp;
    localparam int XLEN = 32;
    localparam int NREG = 32;
    localparam int NRD  = 2;
    localparam int NWR  = 2;

    logic clk = 1'b0;
    logic reset;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    regfile_mp_if #(.XLEN(XLEN), .NREG(NREG), .NRD(NRD), .NWR(NWR)) bus ();

    regfile_mp #(.XLEN(XLEN), .NREG(NREG), .NRD(NRD), .NWR(NWR)) u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    task automatic idle_inputs();
        bus.clr_req = 1'b0;
        bus.we      = '0;
        bus.waddr   = '0;
        bus.wdata   = '0;
    endtask

    task automatic set_reads(input logic [4:0] a0, input logic [4:0] a1);
        bus.raddr = {a1, a0};
    endtask

    task automatic set_writes(input logic [1:0] we, input logic [4:0] a0, input logic [31:0] d0,
                              input logic [4:0] a1, input logic [31:0] d1);
        bus.we    = we;
        bus.waddr = {a1, a0};
        bus.wdata = {d1, d0};
        $display("write we=%b p0 [%0d]=%h p1 [%0d]=%h", we, a0, d0, a1, d1);
    endtask

    // Counts falling edges with ready low, starting at the current one; bounded.
    task automatic count_ready_low(output int n);
        n = 0;
        while (bus.ready !== 1'b1 && n < 100) begin
            n++;
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        int n;
        idle_inputs();
        reset = 1'b1;
        set_reads(5'd5, 5'd6);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        #1;
        total++; if (bus.ready !== 1'b0) begin bad++; $display("FAIL reset_ready got %b expected 0", bus.ready); end
        total++; if (bus.rdata[31:0] !== 32'h0) begin bad++; $display("FAIL reset_rd0 got %h expected 0", bus.rdata[31:0]); end
        total++; if (bus.rdata[63:32] !== 32'h0) begin bad++; $display("FAIL reset_rd1 got %h expected 0", bus.rdata[63:32]); end
        count_ready_low(n);
        total++; if (n !== 31) begin bad++; $display("FAIL reset_clear_len got %0d expected 31", n); end
        for (int a = 0; a < NREG; a++) begin
            set_reads(5'(a), 5'(NREG - 1 - a));
            #1;
            total++; if (bus.rdata[31:0] !== 32'h0) begin bad++; $display("FAIL reset_zero rd0 addr %0d got %h expected 0", a, bus.rdata[31:0]); end
            total++; if (bus.rdata[63:32] !== 32'h0) begin bad++; $display("FAIL reset_zero rd1 addr %0d got %h expected 0", NREG - 1 - a, bus.rdata[63:32]); end
        end
        $display("reset: ready low for %0d cycles", n);
    endtask

    task automatic test_write_read();
        @(negedge clk);
        set_writes(2'b01, 5'd5, 32'hDEADBEEF, 5'd0, 32'h0);
        @(negedge clk);
        idle_inputs();
        set_reads(5'd5, 5'd0);
        #1;
        total++; if (bus.rdata[31:0] !== 32'hDEADBEEF) begin bad++; $display("FAIL wr_read rd0 got %h expected deadbeef", bus.rdata[31:0]); end
        total++; if (bus.rdata[63:32] !== 32'h0) begin bad++; $display("FAIL wr_read x0 got %h expected 0", bus.rdata[63:32]); end
        set_reads(5'd0, 5'd5);
        #1;
        total++; if (bus.rdata[63:32] !== 32'hDEADBEEF) begin bad++; $display("FAIL wr_read rd1 got %h expected deadbeef", bus.rdata[63:32]); end
    endtask

    task automatic test_priority();
        @(negedge clk);
        set_writes(2'b11, 5'd7, 32'h11111111, 5'd7, 32'h22222222);
        @(negedge clk);
        set_writes(2'b11, 5'd0, 32'hFFFFFFFF, 5'd8, 32'h08080808);
        @(negedge clk);
        idle_inputs();
        set_reads(5'd7, 5'd0);
        #1;
        total++; if (bus.rdata[31:0] !== 32'h22222222) begin bad++; $display("FAIL prio_reg7 got %h expected 22222222", bus.rdata[31:0]); end
        total++; if (bus.rdata[63:32] !== 32'h0) begin bad++; $display("FAIL prio_x0 got %h expected 0", bus.rdata[63:32]); end
        set_reads(5'd8, 5'd0);
        #1;
        total++; if (bus.rdata[31:0] !== 32'h08080808) begin bad++; $display("FAIL prio_reg8 got %h expected 08080808", bus.rdata[31:0]); end
    endtask

    task automatic test_clear_req();
        int n;
        @(negedge clk);
        bus.clr_req = 1'b1;
        set_writes(2'b01, 5'd3, 32'hA5A5A5A5, 5'd0, 32'h0);
        set_reads(5'd5, 5'd3);
        @(negedge clk);
        idle_inputs();
        #1;
        total++; if (bus.ready !== 1'b0) begin bad++; $display("FAIL clr_ready got %b expected 0", bus.ready); end
        total++; if (bus.rdata[31:0] !== 32'h0) begin bad++; $display("FAIL clr_rd_forced got %h expected 0", bus.rdata[31:0]); end
        // Walk the clear: write entry 2 after it was cleared, and re-request mid-clear.
        n = 0;
        while (bus.ready !== 1'b1 && n < 100) begin
            idle_inputs();
            if (n == 5) set_writes(2'b01, 5'd2, 32'hBAD0BAD0, 5'd0, 32'h0);
            if (n == 10) bus.clr_req = 1'b1;
            n++;
            @(negedge clk);
        end
        idle_inputs();
        total++; if (n !== 31) begin bad++; $display("FAIL clr_len got %0d expected 31", n); end
        set_reads(5'd3, 5'd2);
        #1;
        total++; if (bus.rdata[31:0] !== 32'h0) begin bad++; $display("FAIL clr_reg3 got %h expected 0", bus.rdata[31:0]); end
        total++; if (bus.rdata[63:32] !== 32'h0) begin bad++; $display("FAIL clr_lost_write got %h expected 0", bus.rdata[63:32]); end
        set_reads(5'd5, 5'd7);
        #1;
        total++; if (bus.rdata[31:0] !== 32'h0) begin bad++; $display("FAIL clr_reg5 got %h expected 0", bus.rdata[31:0]); end
        total++; if (bus.rdata[63:32] !== 32'h0) begin bad++; $display("FAIL clr_reg7 got %h expected 0", bus.rdata[63:32]); end
        $display("clear request: ready low for %0d cycles", n);
    endtask

    task automatic test_reset_mid_clear();
        int n;
        @(negedge clk);
        set_writes(2'b01, 5'd4, 32'h00000077, 5'd0, 32'h0);
        @(negedge clk);
        idle_inputs();
        set_reads(5'd4, 5'd0);
        #1;
        total++; if (bus.rdata[31:0] !== 32'h00000077) begin bad++; $display("FAIL rmc_pre got %h expected 00000077", bus.rdata[31:0]); end
        @(negedge clk);
        bus.clr_req = 1'b1;
        @(negedge clk);
        bus.clr_req = 1'b0;
        repeat (9) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        count_ready_low(n);
        total++; if (n !== 31) begin bad++; $display("FAIL rmc_len got %0d expected 31", n); end
        set_reads(5'd4, 5'd31);
        #1;
        total++; if (bus.rdata[31:0] !== 32'h0) begin bad++; $display("FAIL rmc_reg4 got %h expected 0", bus.rdata[31:0]); end
        $display("reset mid-clear: ready low for %0d cycles", n);
    endtask

    task automatic test_bypass();
        logic [31:0] exp_same0;
        logic [31:0] exp_same1;
`ifdef REGFILE_BYPASS_EN
        exp_same0 = 32'h12345678;
        exp_same1 = 32'hBBBB0001;
`else
        exp_same0 = 32'h00000011;
        exp_same1 = 32'h12345678;
`endif
        @(negedge clk);
        set_writes(2'b01, 5'd9, 32'h00000011, 5'd0, 32'h0);
        @(negedge clk);
        set_writes(2'b01, 5'd9, 32'h12345678, 5'd0, 32'h0);
        set_reads(5'd9, 5'd9);
        #1;
        total++; if (bus.rdata[31:0] !== exp_same0) begin bad++; $display("FAIL byp_same_cycle got %h expected %h", bus.rdata[31:0], exp_same0); end
        @(negedge clk);
        idle_inputs();
        #1;
        total++; if (bus.rdata[31:0] !== 32'h12345678) begin bad++; $display("FAIL byp_next_cycle got %h expected 12345678", bus.rdata[31:0]); end
        @(negedge clk);
        set_writes(2'b11, 5'd9, 32'hAAAA0001, 5'd9, 32'hBBBB0001);
        #1;
        total++; if (bus.rdata[63:32] !== exp_same1) begin bad++; $display("FAIL byp_prio got %h expected %h", bus.rdata[63:32], exp_same1); end
        @(negedge clk);
        set_writes(2'b01, 5'd0, 32'hFFFFFFFF, 5'd0, 32'h0);
        set_reads(5'd0, 5'd9);
        #1;
        total++; if (bus.rdata[31:0] !== 32'h0) begin bad++; $display("FAIL byp_x0 got %h expected 0", bus.rdata[31:0]); end
        total++; if (bus.rdata[63:32] !== 32'hBBBB0001) begin bad++; $display("FAIL byp_prio_stored got %h expected bbbb0001", bus.rdata[63:32]); end
        @(negedge clk);
        idle_inputs();
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            set_writes(2'b11, 5'(10 + i), 32'h1000 + i, 5'(20 + i), 32'h2000 + i);
        end
        @(negedge clk);
        idle_inputs();
        for (int i = 0; i < 4; i++) begin
            set_reads(5'(10 + i), 5'(20 + i));
            #1;
            total++; if (bus.rdata[31:0] !== 32'h1000 + i) begin bad++; $display("FAIL b2b p0 addr %0d got %h expected %h", 10 + i, bus.rdata[31:0], 32'h1000 + i); end
            total++; if (bus.rdata[63:32] !== 32'h2000 + i) begin bad++; $display("FAIL b2b p1 addr %0d got %h expected %h", 20 + i, bus.rdata[63:32], 32'h2000 + i); end
        end
    endtask

    initial begin
        reset = 1'b1;
        idle_inputs();
        set_reads(5'd0, 5'd0);
        test_reset();
        test_write_read();
        test_priority();
        test_clear_req();
        test_reset_mid_clear();
        test_bypass();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Hard stop in case a wait ever runs away.
    initial begin
        #200000;
        $display("FAIL timeout got running expected finished");
        $fatal(1, "timeout");
    end
endmodule
